// File: rtl/packer_pkg.sv
// packer_pkg: shared types and defaults for the FIFO_8 word packer.
// Holds the packer state enum, default sizes and the byte-lane width.
package packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_t;

  localparam int BYTES_PER_WORD_DEF = 4;
  localparam int FIFO_DEPTH_DEF     = 8;
  localparam int TIMEOUT_CYC_DEF    = 16;
  localparam int LANE_W             = 8;

  // Bit offset of byte lane n inside a packed word.
  function automatic int lane_lsb(input int n);
    return n * LANE_W;
  endfunction

endpackage

// File: rtl/fifo8_occ_tracker.sv
// fifo8_occ_tracker: shadow occupancy count for FIFO_8, which has no
// empty flag.
// Ports: clk, rst_n (async, active-low), wen (upstream write copy),
//   ren (our read strobe), occ (0..FIFO_DEPTH), nonempty (occ != 0).
module fifo8_occ_tracker
  import packer_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int OW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen,
  input  logic          ren,
  output logic [OW-1:0] occ,
  output logic          nonempty
);

  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

  logic          inc;
  logic          dec;
  logic [OW-1:0] occ_nxt;

  // A write into a full FIFO only lands when a read frees a slot
  // on the same edge; a read never takes the count below zero.
  always_comb begin
    inc     = wen & ((occ != DEPTH_C) | ren);
    dec     = ren & (occ != '0);
    occ_nxt = occ;
    if (inc && !dec) begin
      occ_nxt = occ + OW'(1);
    end else if (dec && !inc) begin
      occ_nxt = occ - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else begin
      occ <= occ_nxt;
    end
  end

  assign nonempty = (occ != '0);

endmodule

// File: rtl/fifo8_word_packer.sv
// fifo8_word_packer: drains FIFO_8 and packs bytes little-endian into
// words presented on a valid/ready port.
// Ports: clk, rst_n (async, active-low); fifo_wen_mon, fifo_dout,
//   fifo_error in from FIFO_8; fifo_ren out to FIFO_8; word,
//   word_valid, word_bytes out with word_ready in; drop_err sticky.
// Build option: define PACKER_TIMEOUT_EN to flush partial words
//   after TIMEOUT_CYC idle cycles.
module fifo8_word_packer
  import packer_pkg::*;
#(
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_wen_mon,
  input  logic [7:0]                       fifo_dout,
  input  logic                             fifo_error,
  output logic                             fifo_ren,
  output logic [LANE_W*BYTES_PER_WORD-1:0] word,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic [3:0]                       word_bytes,
  output logic                             drop_err
);

  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] BPW_C = CW'(BYTES_PER_WORD);
  localparam logic [3:0]    BPW_B = 4'(BYTES_PER_WORD);

  if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 ||
      FIFO_DEPTH < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("fifo8_word_packer: unsupported parameters");
  end

  pk_state_t     state;
  logic          rd_pend;
  logic [CW-1:0] issued;
  logic [CW-1:0] got;
  logic [CW-1:0] issued_eff;
  logic [OW-1:0] occ;
  logic          nonempty;
  logic          avail_next;
  logic          resp_ok;
  logic          resp_err;
  logic          can_rd;
  logic          last_byte;
  logic          flush;

  fifo8_occ_tracker #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .OW         (OW)
  ) u_occ (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (fifo_wen_mon),
    .ren      (fifo_ren),
    .occ      (occ),
    .nonempty (nonempty)
  );

  // fifo_ren is registered, so the decision for the next cycle must
  // use the occupancy after this edge, not the current count.
  // A failed read gives its slot back so the byte is re-requested.
  always_comb begin
    resp_ok    = rd_pend & ~fifo_error;
    resp_err   = rd_pend & fifo_error;
    issued_eff = issued - CW'(resp_err);
    avail_next = fifo_wen_mon
               | (occ > OW'(1))
               | (nonempty & ~fifo_ren);
    can_rd     = avail_next & (issued_eff < BPW_C);
    last_byte  = resp_ok & (got == BPW_C - CW'(1));
  end

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] timer;
  logic          partial;

  // Only flush when nothing is in flight or waiting in the FIFO,
  // so a late byte can never land in a word already handed out.
  always_comb begin
    partial = (state == FILL) & (got != '0) & (got < BPW_C);
    flush   = partial & (timer == T_LAST)
            & ~rd_pend & ~fifo_ren & ~nonempty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (rd_pend || !partial || flush) begin
      timer <= '0;
    end else if (timer != T_LAST) begin
      timer <= timer + TW'(1);
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      fifo_ren   <= 1'b0;
      rd_pend    <= 1'b0;
      issued     <= '0;
      got        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      word_bytes <= '0;
      drop_err   <= 1'b0;
    end else begin
      rd_pend <= fifo_ren;
      unique case (state)
        FILL: begin
          if (flush) begin
            fifo_ren   <= 1'b0;
            word_valid <= 1'b1;
            word_bytes <= 4'(got);
            state      <= HOLD;
          end else begin
            fifo_ren <= can_rd;
            issued   <= issued_eff + CW'(can_rd);
            if (resp_ok) begin
              word[lane_lsb(int'(got)) +: LANE_W] <= fifo_dout;
              got <= got + CW'(1);
            end
            if (resp_err) begin
              drop_err <= 1'b1;
            end
            if (last_byte) begin
              word_valid <= 1'b1;
              word_bytes <= BPW_B;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          fifo_ren <= 1'b0;
          // Lanes clear on hand-off so a flushed partial word
          // carries zeros in its unfilled lanes.
          if (word_ready) begin
            word_valid <= 1'b0;
            word       <= '0;
            word_bytes <= '0;
            got        <= '0;
            state      <= FILL;
            fifo_ren   <= avail_next;
            issued     <= CW'(avail_next);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo8_word_packer.sv
// tb_fifo8_word_packer: directed bench for fifo8_word_packer with a
// behavioural FIFO_8 upstream and an output word monitor.
module tb_fifo8_word_packer;

  localparam int BPW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           fifo_wen_mon = 1'b0;
  logic [7:0]     wdata = 8'h00;
  logic [7:0]     fifo_dout = 8'h00;
  logic           fifo_error = 1'b0;
  logic           fifo_ren;
  logic [8*BPW-1:0] word;
  logic           word_valid;
  logic           word_ready = 1'b0;
  logic [3:0]     word_bytes;
  logic           drop_err;

  int total = 0;
  int bad = 0;

  fifo8_word_packer #(
    .BYTES_PER_WORD (BPW),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYC    (16)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_wen_mon (fifo_wen_mon),
    .fifo_dout    (fifo_dout),
    .fifo_error   (fifo_error),
    .fifo_ren     (fifo_ren),
    .word         (word),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_bytes   (word_bytes),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  // FIFO_8 model: read data and error appear one cycle after ren.
  // Read number err_at is answered with fifo_error (byte lost).
  logic [7:0] fq[$];
  int rd_cnt = 0;
  int err_at = -1;

  always @(posedge clk) begin
    fifo_error <= 1'b0;
    if (fifo_ren) begin
      rd_cnt <= rd_cnt + 1;
      if (fq.size() == 0) begin
        fifo_error <= 1'b1;
      end else begin
        fifo_dout <= fq.pop_front();
        if (rd_cnt + 1 == err_at) fifo_error <= 1'b1;
      end
    end
    if (fifo_wen_mon) begin
      if (fq.size() < 8) fq.push_back(wdata);
      else fifo_error <= 1'b1;
    end
  end

  logic [8*BPW-1:0] rx_w[$];
  logic [3:0]       rx_b[$];
  int valid_cyc = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (word_valid) valid_cyc <= valid_cyc + 1;
      if (word_valid && word_ready) begin
        rx_w.push_back(word);
        rx_b.push_back(word_bytes);
      end
    end
  end

  function automatic logic [8*BPW-1:0] rx_at(input int i);
    if (i < rx_w.size()) return rx_w[i];
    return 'x;
  endfunction

  function automatic logic [3:0] rxb_at(input int i);
    if (i < rx_b.size()) return rx_b[i];
    return 'x;
  endfunction

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    fifo_wen_mon = 1'b1;
    wdata = b;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    fifo_wen_mon = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, output bit ok);
    int k;
    k = 0;
    while (rx_w.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    ok = (rx_w.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (fifo_ren !== 1'b0) begin
      bad++; $display("FAIL reset_ren: got %b want 0", fifo_ren);
    end
    total++;
    if (word !== 32'h0) begin
      bad++; $display("FAIL reset_word: got %h want 0", word);
    end
    total++;
    if (word_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", word_valid);
    end
    total++;
    if (word_bytes !== 4'd0) begin
      bad++; $display("FAIL reset_bytes: got %0d want 0", word_bytes);
    end
    total++;
    if (drop_err !== 1'b0) begin
      bad++; $display("FAIL reset_drop: got %b want 0", drop_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int r0, c0, v0;
    bit ok;
    r0 = rx_w.size(); c0 = rd_cnt; v0 = valid_cyc;
    word_ready = 1'b1;
    put(8'd87); put(8'd85); put(8'd0); put(8'd77);
    idle(0);
    wait_rx(r0 + 1, ok);
    repeat (4) @(negedge clk);
    total++;
    if (!ok) begin
      bad++; $display("FAIL basic_done: got no word want 1 word");
    end
    total++;
    if (rx_at(r0) !== 32'h4D005557) begin
      bad++; $display("FAIL basic_word: got %h want 4d005557", rx_at(r0));
    end
    total++;
    if (rxb_at(r0) !== 4'd4) begin
      bad++; $display("FAIL basic_bytes: got %0d want 4", rxb_at(r0));
    end
    total++;
    if (rd_cnt - c0 != 4) begin
      bad++; $display("FAIL basic_ren: got %0d want 4", rd_cnt - c0);
    end
    total++;
    if (valid_cyc - v0 != 1) begin
      bad++; $display("FAIL basic_vcyc: got %0d want 1", valid_cyc - v0);
    end
    total++;
    if (drop_err !== 1'b0) begin
      bad++; $display("FAIL basic_drop: got %b want 0", drop_err);
    end
  endtask

  task automatic test_backpressure();
    int r0, c0;
    bit ok, ren_seen;
    r0 = rx_w.size(); c0 = rd_cnt; ren_seen = 1'b0;
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) put(8'(i));
    idle(0);
    repeat (15) begin
      @(negedge clk);
      if (fifo_ren) ren_seen = 1'b1;
    end
    total++;
    if (ren_seen !== 1'b0) begin
      bad++; $display("FAIL bp_ren_hold: got 1 want 0");
    end
    total++;
    if (rd_cnt - c0 != 4) begin
      bad++; $display("FAIL bp_reads: got %0d want 4", rd_cnt - c0);
    end
    total++;
    if (word_valid !== 1'b1) begin
      bad++; $display("FAIL bp_valid: got %b want 1", word_valid);
    end
    total++;
    if (word !== 32'h04030201) begin
      bad++; $display("FAIL bp_held: got %h want 04030201", word);
    end
    total++;
    if (u_dut.u_occ.occ !== 4'd4) begin
      bad++; $display("FAIL bp_occ: got %0d want 4", u_dut.u_occ.occ);
    end
    word_ready = 1'b1;
    wait_rx(r0 + 2, ok);
    repeat (3) @(negedge clk);
    total++;
    if (rx_at(r0) !== 32'h04030201) begin
      bad++; $display("FAIL bp_word0: got %h want 04030201", rx_at(r0));
    end
    total++;
    if (rx_at(r0 + 1) !== 32'h08070605) begin
      bad++; $display("FAIL bp_word1: got %h want 08070605", rx_at(r0 + 1));
    end
    total++;
    if (rd_cnt - c0 != 8) begin
      bad++; $display("FAIL bp_reads_all: got %0d want 8", rd_cnt - c0);
    end
  endtask

  task automatic test_same_cycle();
    int r0, c0;
    bit ok;
    r0 = rx_w.size(); c0 = rd_cnt;
    word_ready = 1'b1;
    put(8'h21); put(8'h22);
    @(negedge clk);
    fifo_wen_mon = 1'b0;
    total++;
    if (u_dut.u_occ.occ !== 4'd1) begin
      bad++; $display("FAIL same_occ: got %0d want 1", u_dut.u_occ.occ);
    end
    total++;
    if (fifo_ren !== 1'b1) begin
      bad++; $display("FAIL same_ren: got %b want 1", fifo_ren);
    end
    put(8'h23); put(8'h24);
    idle(0);
    wait_rx(r0 + 1, ok);
    repeat (3) @(negedge clk);
    total++;
    if (rx_at(r0) !== 32'h24232221) begin
      bad++; $display("FAIL same_word: got %h want 24232221", rx_at(r0));
    end
    total++;
    if (drop_err !== 1'b0) begin
      bad++; $display("FAIL same_drop: got %b want 0", drop_err);
    end
    total++;
    if (rd_cnt - c0 != 4) begin
      bad++; $display("FAIL same_reads: got %0d want 4", rd_cnt - c0);
    end
  endtask

  task automatic test_error();
    int r0, c0;
    bit ok;
    r0 = rx_w.size(); c0 = rd_cnt;
    word_ready = 1'b1;
    err_at = rd_cnt + 1;
    put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4); put(8'hA5);
    idle(0);
    wait_rx(r0 + 1, ok);
    repeat (3) @(negedge clk);
    err_at = -1;
    total++;
    if (rx_at(r0) !== 32'hA5A4A3A2) begin
      bad++; $display("FAIL err_word: got %h want a5a4a3a2", rx_at(r0));
    end
    total++;
    if (rxb_at(r0) !== 4'd4) begin
      bad++; $display("FAIL err_bytes: got %0d want 4", rxb_at(r0));
    end
    total++;
    if (drop_err !== 1'b1) begin
      bad++; $display("FAIL err_drop: got %b want 1", drop_err);
    end
    total++;
    if (rd_cnt - c0 != 5) begin
      bad++; $display("FAIL err_reads: got %0d want 5", rd_cnt - c0);
    end
  endtask

`ifdef PACKER_TIMEOUT_EN
  task automatic test_partial();
    int k;
    word_ready = 1'b0;
    put(8'h66); put(8'h59);
    idle(6);
    total++;
    if (word_valid !== 1'b0) begin
      bad++; $display("FAIL to_early: got %b want 0", word_valid);
    end
    k = 0;
    while (word_valid !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (word_valid !== 1'b1) begin
      bad++; $display("FAIL to_valid: got %b want 1", word_valid);
    end
    total++;
    if (word !== 32'h00005966) begin
      bad++; $display("FAIL to_word: got %h want 00005966", word);
    end
    total++;
    if (word_bytes !== 4'd2) begin
      bad++; $display("FAIL to_bytes: got %0d want 2", word_bytes);
    end
    word_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask
`else
  task automatic test_partial();
    int r0;
    bit ok;
    r0 = rx_w.size();
    word_ready = 1'b1;
    put(8'h66); put(8'h59);
    idle(40);
    total++;
    if (word_valid !== 1'b0) begin
      bad++; $display("FAIL part_valid: got %b want 0", word_valid);
    end
    total++;
    if (rx_w.size() != r0) begin
      bad++; $display("FAIL part_none: got %0d want %0d", rx_w.size(), r0);
    end
    put(8'h77); put(8'h88);
    idle(0);
    wait_rx(r0 + 1, ok);
    total++;
    if (rx_at(r0) !== 32'h88775966) begin
      bad++; $display("FAIL part_word: got %h want 88775966", rx_at(r0));
    end
    total++;
    if (rxb_at(r0) !== 4'd4) begin
      bad++; $display("FAIL part_bytes: got %0d want 4", rxb_at(r0));
    end
  endtask
`endif

  task automatic test_reset_mid();
    int r0, c0;
    bit ok;
    word_ready = 1'b1;
    put(8'hC0); put(8'hC1); put(8'hC2);
    @(negedge clk);
    fifo_wen_mon = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (word !== 32'h0000C1C0) begin
      bad++; $display("FAIL mid_partial: got %h want 0000c1c0", word);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (word !== 32'h0) begin
      bad++; $display("FAIL mid_word: got %h want 0", word);
    end
    total++;
    if (drop_err !== 1'b0) begin
      bad++; $display("FAIL mid_drop: got %b want 0", drop_err);
    end
    total++;
    if (fifo_ren !== 1'b0 || word_valid !== 1'b0 || word_bytes !== 4'd0) begin
      bad++; $display("FAIL mid_ctl: got %b%b%0d want 000", fifo_ren, word_valid, word_bytes);
    end
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rx_w.size(); c0 = rd_cnt;
    put(8'hD0); put(8'hD1); put(8'hD2); put(8'hD3);
    idle(0);
    wait_rx(r0 + 1, ok);
    repeat (3) @(negedge clk);
    total++;
    if (rx_at(r0) !== 32'hD3D2D1D0) begin
      bad++; $display("FAIL mid_clean: got %h want d3d2d1d0", rx_at(r0));
    end
    total++;
    if (drop_err !== 1'b0) begin
      bad++; $display("FAIL mid_drop2: got %b want 0", drop_err);
    end
    total++;
    if (rd_cnt - c0 != 4) begin
      bad++; $display("FAIL mid_reads: got %0d want 4", rd_cnt - c0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_same_cycle();
    test_error();
    test_partial();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo8_word_packer.md
Name: fifo8_word_packer

Overview:
- Downstream consumer of FIFO_8.
- Drains the FIFO byte stream by issuing ren and packs BYTES_PER_WORD consecutive bytes, little-endian, into one word.
- Presents each word on a valid/ready interface to the next stage.
- FIFO_8 exposes no empty flag, so the packer keeps a shadow occupancy count. It updates the count from the upstream write strobe and its own reads, and uses fifo_error to discard illegal reads.

Parameters:
- BYTES_PER_WORD, 4, bytes packed per output word (2..8).
- FIFO_DEPTH, 8, FIFO_8 capacity; shadow counter saturates here.
- TIMEOUT_CYC, 16, idle cycles before a partial-word flush (only with PACKER_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_wen_mon  in  1  copy of the upstream wen driven into FIFO_8.
- fifo_dout  in  8  FIFO_8 dout.
- fifo_error  in  1  FIFO_8 error.
- fifo_ren  out  1  read strobe to FIFO_8 ren.
- word  out  8*BYTES_PER_WORD  packed word; byte 0 (first read) in [7:0].
- word_valid  out  1  word holds a complete word.
- word_ready  in  1  downstream accept.
- word_bytes  out  4  count of valid bytes in word (BYTES_PER_WORD unless a timeout flush occurred).
- drop_err  out  1  sticky; a read returned fifo_error.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: fifo_ren=0, word=0, word_valid=0, word_bytes=0, drop_err=0, occ=0, issued=0, got=0, state=FILL, timer=0.
- FIFO_8 contract:
  - Read data appears on fifo_dout one cycle after the edge that samples ren=1.
  - fifo_error is high in that same response cycle when the read hit an empty FIFO.
  - A write to a full FIFO also raises fifo_error; the packer ignores errors not paired with its own pending read.
  - Simultaneous wen+ren is a legal read and write.
- Shadow occupancy occ (0..FIFO_DEPTH), per edge:
  - +1 if fifo_wen_mon and (occ<FIFO_DEPTH or fifo_ren).
  - −1 if fifo_ren.
  - Both: unchanged.
  - Never wraps.
- Response tracking: rd_pend register = fifo_ren delayed one cycle; marks a response cycle.
- State FILL:
  - fifo_ren = (occ>0) and (issued<BYTES_PER_WORD). Registered, so back-to-back reads give one byte per cycle.
  - On rd_pend and !fifo_error: fifo_dout goes into byte lane got; got+1.
  - On rd_pend and fifo_error: byte dropped, drop_err<=1, issued−1 so the slot is re-read.
  - When got reaches BYTES_PER_WORD: word_valid<=1, word_bytes<=BYTES_PER_WORD, go to HOLD.
- State HOLD:
  - fifo_ren=0; word, word_valid, word_bytes held stable.
  - On word_valid&&word_ready: word_valid<=0, issued/got<=0, go to FILL.
  - FILL may issue a read in the cycle right after acceptance, never in the accept cycle itself.
- Throughput: BYTES_PER_WORD+1 cycles per word minimum, plus handshake stall.
- Boundary cases:
  - occ=0 → no ren; packer idles in FILL with partial bytes kept.
  - word_ready held low → no reads issued; FIFO backs up upstream.
  - drop_err clears only on reset.
  - Reset mid-word discards partial bytes and the pending response; the response arriving after reset release is ignored (rd_pend reset to 0).

Optional Feature:
- Macro PACKER_TIMEOUT_EN.
- When defined:
  - In FILL with 0<got<BYTES_PER_WORD, timer counts cycles with no response.
  - timer resets to 0 on any response.
  - When timer reaches TIMEOUT_CYC−1 and no read is pending: unfilled lanes = 0, word_bytes<=got, word_valid<=1, go to HOLD.
- When undefined: no timer logic; partial words wait indefinitely; word_bytes is always BYTES_PER_WORD when valid.

Decomposition:
- Shared package packer_pkg holds:
  - state enum {FILL, HOLD}.
  - Default constants BYTES_PER_WORD_DEF=4, FIFO_DEPTH_DEF=8.
  - Byte-lane width constant 8.
- Natural sub-module: fifo8_occ_tracker (shadow occupancy counter, outputs occ and nonempty).
- The packer FSM, lane register and timer stay in the top.

Test Plan:
- Write 87,85,0,77 on 4 cycles, word_ready=1 → 4 ren pulses, word=0x4D005557, word_valid one cycle, word_bytes=4, drop_err=0.
- Write 8 bytes 0x01..0x08 with word_ready=0 → first word 0x04030201 held; fifo_ren stays 0 after 4 reads. Raise word_ready → word accepted, then 0x08070605 produced.
- Write+read same cycle with occ=1 (wen_mon=1, ren=1) → occ stays 1; next word completes correctly with no drop.
- Force fifo_error on one response cycle → byte discarded, drop_err=1, one extra ren issued, word still contains 4 valid bytes in order.
- Assert rst_n=0 for half a cycle mid-word (got=2) → all outputs return to reset values immediately; the next 4 writes yield a clean word.
- With PACKER_TIMEOUT_EN and TIMEOUT_CYC=16: write 0x66,0x59 then idle → after 16 idle cycles word=0x00005966, word_bytes=2, word_valid=1.
